branch_resolution_queue: RTL and testbench

BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

---
 rtl/branch_resolution_queue.sv | 259 +++++++++++++++++++++++++
 tb/tb_branch_resolution_queue.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolution_queue
// Brief    : Circular queue of in-flight branches/JALRs. Decode allocates up
//            to three entries per cycle, execute resolves them in any order,
//            and the queue emits up to three resolved entries per cycle to
//            fetch in allocation order. A mispredicting entry flushes all
//            younger entries and requests a RAS restore.
//            Optional macro BRQ_PERF_COUNTERS_EN enables the 32-bit
//            misprediction event counter on mispredict_count_o.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolution_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int ENTRIES     = 32,
  parameter int INDEX_WIDTH = $clog2(ENTRIES),
  parameter int TAG_W       = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               alloc_valid_i,
  input  logic [2:0]               alloc_is_jalr_i,
  input  logic [DATA_WIDTH-1:0]    alloc_pc_i_0,
  input  logic [DATA_WIDTH-1:0]    alloc_pc_i_1,
  input  logic [DATA_WIDTH-1:0]    alloc_pc_i_2,
  input  logic [INDEX_WIDTH+2:0]   alloc_global_history_i_0,
  input  logic [INDEX_WIDTH+2:0]   alloc_global_history_i_1,
  input  logic [INDEX_WIDTH+2:0]   alloc_global_history_i_2,
  input  logic [2:0]               alloc_ras_tos_i_0,
  input  logic [2:0]               alloc_ras_tos_i_1,
  input  logic [2:0]               alloc_ras_tos_i_2,
  output logic                     alloc_ready_o,
  output logic [TAG_W-1:0]         alloc_tag_o_0,
  output logic [TAG_W-1:0]         alloc_tag_o_1,
  output logic [TAG_W-1:0]         alloc_tag_o_2,
  input  logic [2:0]               resolve_valid_i,
  input  logic [TAG_W-1:0]         resolve_tag_i_0,
  input  logic [TAG_W-1:0]         resolve_tag_i_1,
  input  logic [TAG_W-1:0]         resolve_tag_i_2,
  input  logic [2:0]               resolve_mispredict_i,
  input  logic [DATA_WIDTH-1:0]    resolve_correct_pc_i_0,
  input  logic [DATA_WIDTH-1:0]    resolve_correct_pc_i_1,
  input  logic [DATA_WIDTH-1:0]    resolve_correct_pc_i_2,
  output logic                     misprediction_o_0,
  output logic                     misprediction_o_1,
  output logic                     misprediction_o_2,
  output logic                     update_valid_o_0,
  output logic                     update_valid_o_1,
  output logic                     update_valid_o_2,
  output logic                     is_jalr_o_0,
  output logic                     is_jalr_o_1,
  output logic                     is_jalr_o_2,
  output logic [DATA_WIDTH-1:0]    pc_at_prediction_o_0,
  output logic [DATA_WIDTH-1:0]    pc_at_prediction_o_1,
  output logic [DATA_WIDTH-1:0]    pc_at_prediction_o_2,
  output logic [DATA_WIDTH-1:0]    correct_pc_o_0,
  output logic [DATA_WIDTH-1:0]    correct_pc_o_1,
  output logic [DATA_WIDTH-1:0]    correct_pc_o_2,
  output logic [INDEX_WIDTH+2:0]   update_global_history_o_0,
  output logic [INDEX_WIDTH+2:0]   update_global_history_o_1,
  output logic [INDEX_WIDTH+2:0]   update_global_history_o_2,
  output logic                     ras_restore_en_o,
  output logic [2:0]               ras_restore_tos_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [TAG_W:0]           count_o,
  output logic [31:0]              mispredict_count_o
);

  localparam int                 c_HIST_W = INDEX_WIDTH + 3;
  localparam int                 c_CNT_W  = TAG_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_SLOTS  = c_CNT_W'(3);

  // Entry storage: control flags are reset, payload is not
  logic [DEPTH-1:0]      r_valid, r_resolved, r_mispredict, r_is_jalr;
  logic [DATA_WIDTH-1:0] r_pc   [DEPTH];
  logic [DATA_WIDTH-1:0] r_cpc  [DEPTH];
  logic [c_HIST_W-1:0]   r_hist [DEPTH];
  logic [2:0]            r_ras  [DEPTH];

  logic [TAG_W-1:0]   r_head, r_tail;
  logic [c_CNT_W-1:0] r_count;

  // Per-slot views of the flattened ports
  logic [DATA_WIDTH-1:0] w_alloc_pc   [3];
  logic [c_HIST_W-1:0]   w_alloc_hist [3];
  logic [2:0]            w_alloc_ras  [3];
  logic [TAG_W-1:0]      w_res_tag    [3];
  logic [DATA_WIDTH-1:0] w_res_cpc    [3];

  assign w_alloc_pc[0]   = alloc_pc_i_0;
  assign w_alloc_pc[1]   = alloc_pc_i_1;
  assign w_alloc_pc[2]   = alloc_pc_i_2;
  assign w_alloc_hist[0] = alloc_global_history_i_0;
  assign w_alloc_hist[1] = alloc_global_history_i_1;
  assign w_alloc_hist[2] = alloc_global_history_i_2;
  assign w_alloc_ras[0]  = alloc_ras_tos_i_0;
  assign w_alloc_ras[1]  = alloc_ras_tos_i_1;
  assign w_alloc_ras[2]  = alloc_ras_tos_i_2;
  assign w_res_tag[0]    = resolve_tag_i_0;
  assign w_res_tag[1]    = resolve_tag_i_1;
  assign w_res_tag[2]    = resolve_tag_i_2;
  assign w_res_cpc[0]    = resolve_correct_pc_i_0;
  assign w_res_cpc[1]    = resolve_correct_pc_i_1;
  assign w_res_cpc[2]    = resolve_correct_pc_i_2;

  logic                  w_alloc_ready, w_alloc_en, w_any_misp;
  logic [2:0]            w_alloc_v, w_res_hit, w_ok, w_upd, w_misp;
  logic [1:0]            w_n_alloc, w_n_ret;
  logic [TAG_W-1:0]      w_alloc_idx [3];
  logic [TAG_W-1:0]      w_hidx      [3];
  logic [DATA_WIDTH-1:0] w_out_pc    [3];
  logic [DATA_WIDTH-1:0] w_out_cpc   [3];
  logic [c_HIST_W-1:0]   w_out_hist  [3];
  logic [2:0]            w_out_jalr;

  // Readiness depends on registered occupancy only, so decode sees a stable value
  assign w_alloc_ready = (c_DEPTH - r_count) >= c_SLOTS;
  assign w_any_misp    = |w_misp;
  assign w_alloc_en    = w_alloc_ready & ~w_any_misp;

  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_slot
      assign w_alloc_idx[k] = r_tail + TAG_W'(k);
      assign w_alloc_v[k]   = alloc_valid_i[k] & w_alloc_en;
      assign w_res_hit[k]   = resolve_valid_i[k] & r_valid[w_res_tag[k]]
                              & ~r_resolved[w_res_tag[k]];
      assign w_hidx[k]      = r_head + TAG_W'(k);
      assign w_ok[k]        = r_valid[w_hidx[k]] & r_resolved[w_hidx[k]];
      assign w_misp[k]      = w_upd[k] & r_mispredict[w_hidx[k]];
      assign w_out_pc[k]    = w_upd[k] ? r_pc[w_hidx[k]]   : '0;
      assign w_out_cpc[k]   = w_upd[k] ? r_cpc[w_hidx[k]]  : '0;
      assign w_out_hist[k]  = w_upd[k] ? r_hist[w_hidx[k]] : '0;
      assign w_out_jalr[k]  = w_upd[k] & r_is_jalr[w_hidx[k]];
    end
  endgenerate

  // An emitted slot needs every older slot emitted and none of them mispredicting;
  // written flat so no bit depends on another bit of the same vector
  assign w_upd[0] = w_ok[0];
  assign w_upd[1] = w_ok[0] & ~r_mispredict[w_hidx[0]] & w_ok[1];
  assign w_upd[2] = w_ok[0] & ~r_mispredict[w_hidx[0]] & w_ok[1]
                    & ~r_mispredict[w_hidx[1]] & w_ok[2];

  assign w_n_alloc = {1'b0, w_alloc_v[0]} + {1'b0, w_alloc_v[1]} + {1'b0, w_alloc_v[2]};
  assign w_n_ret   = {1'b0, w_upd[0]} + {1'b0, w_upd[1]} + {1'b0, w_upd[2]};

  // Select the RAS checkpoint of the single mispredicting slot, if any
  always_comb begin
    ras_restore_tos_o = 3'd0;
    if (w_misp[0])      ras_restore_tos_o = r_ras[w_hidx[0]];
    else if (w_misp[1]) ras_restore_tos_o = r_ras[w_hidx[1]];
    else if (w_misp[2]) ras_restore_tos_o = r_ras[w_hidx[2]];
  end

  // Pointer and occupancy update; a misprediction retires the emitted entries and drops the rest
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_any_misp) begin
      r_head  <= r_head + TAG_W'(w_n_ret);
      r_tail  <= r_head + TAG_W'(w_n_ret);
      r_count <= '0;
    end else begin
      r_head  <= r_head + TAG_W'(w_n_ret);
      r_tail  <= r_tail + TAG_W'(w_n_alloc);
      r_count <= r_count + c_CNT_W'(w_n_alloc) - c_CNT_W'(w_n_ret);
    end
  end

  // Entry flags: resolve, allocate, retire, then flush overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= '0;
      r_resolved   <= '0;
      r_mispredict <= '0;
    end else begin
      // Descending so that port 0 wins if two ports hit the same tag
      for (int p = 2; p >= 0; p--) begin
        if (w_res_hit[p]) begin
          r_resolved[w_res_tag[p]]   <= 1'b1;
          r_mispredict[w_res_tag[p]] <= resolve_mispredict_i[p];
        end
      end
      for (int s = 0; s < 3; s++) begin
        if (w_alloc_v[s]) begin
          r_valid[w_alloc_idx[s]]      <= 1'b1;
          r_resolved[w_alloc_idx[s]]   <= 1'b0;
          r_mispredict[w_alloc_idx[s]] <= 1'b0;
        end
        if (w_upd[s]) r_valid[w_hidx[s]] <= 1'b0;
      end
      if (w_any_misp) r_valid <= '0;
    end
  end

  // Entry payload written on allocation, target latched on first resolve
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (w_alloc_v[s]) begin
        r_pc[w_alloc_idx[s]]      <= w_alloc_pc[s];
        r_hist[w_alloc_idx[s]]    <= w_alloc_hist[s];
        r_ras[w_alloc_idx[s]]     <= w_alloc_ras[s];
        r_is_jalr[w_alloc_idx[s]] <= alloc_is_jalr_i[s];
      end
    end
    for (int p = 2; p >= 0; p--) begin
      if (w_res_hit[p]) r_cpc[w_res_tag[p]] <= w_res_cpc[p];
    end
  end

`ifdef BRQ_PERF_COUNTERS_EN
  logic [31:0] r_misp_cnt;

  // Count cycles that emit a misprediction, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset)           r_misp_cnt <= '0;
    else if (w_any_misp) r_misp_cnt <= r_misp_cnt + 32'd1;
  end

  assign mispredict_count_o = r_misp_cnt;
`else
  assign mispredict_count_o = 32'd0;
`endif

  assign alloc_ready_o             = w_alloc_ready;
  assign alloc_tag_o_0             = w_alloc_idx[0];
  assign alloc_tag_o_1             = w_alloc_idx[1];
  assign alloc_tag_o_2             = w_alloc_idx[2];
  assign update_valid_o_0          = w_upd[0];
  assign update_valid_o_1          = w_upd[1];
  assign update_valid_o_2          = w_upd[2];
  assign misprediction_o_0         = w_misp[0];
  assign misprediction_o_1         = w_misp[1];
  assign misprediction_o_2         = w_misp[2];
  assign is_jalr_o_0               = w_out_jalr[0];
  assign is_jalr_o_1               = w_out_jalr[1];
  assign is_jalr_o_2               = w_out_jalr[2];
  assign pc_at_prediction_o_0      = w_out_pc[0];
  assign pc_at_prediction_o_1      = w_out_pc[1];
  assign pc_at_prediction_o_2      = w_out_pc[2];
  assign correct_pc_o_0            = w_out_cpc[0];
  assign correct_pc_o_1            = w_out_cpc[1];
  assign correct_pc_o_2            = w_out_cpc[2];
  assign update_global_history_o_0 = w_out_hist[0];
  assign update_global_history_o_1 = w_out_hist[1];
  assign update_global_history_o_2 = w_out_hist[2];
  assign ras_restore_en_o          = w_any_misp;
  assign empty_o                   = (r_count == '0);
  assign full_o                    = (r_count == c_DEPTH);
  assign count_o                   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolution_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolution_queue
// Brief    : Self-checking bench for branch_resolution_queue. A queue model
//            of in-flight entries predicts every cycle's outputs; directed
//            steps cover ordering, mispredict flush, back-pressure, tag wrap,
//            duplicate/stray resolves and mid-stream reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolution_queue;

  logic clk, reset;
  logic [2:0] av, aj, rv, rm;
  logic [31:0] a_pc[3], rs_cpc[3];
  logic [7:0] a_hist[3];
  logic [2:0] a_ras[3];
  logic [3:0] rs_tag[3];

  logic ready, ras_en, empty, full;
  logic [3:0] tag0, tag1, tag2;
  logic [2:0] d_uv, d_mp, d_jalr, ras_tos;
  logic [31:0] d_pc[3], d_cpc[3], misp_cnt;
  logic [7:0] d_hist[3];
  logic [4:0] count;

  branch_resolution_queue dut (
    .clk(clk), .reset(reset),
    .alloc_valid_i(av), .alloc_is_jalr_i(aj),
    .alloc_pc_i_0(a_pc[0]), .alloc_pc_i_1(a_pc[1]), .alloc_pc_i_2(a_pc[2]),
    .alloc_global_history_i_0(a_hist[0]), .alloc_global_history_i_1(a_hist[1]),
    .alloc_global_history_i_2(a_hist[2]),
    .alloc_ras_tos_i_0(a_ras[0]), .alloc_ras_tos_i_1(a_ras[1]), .alloc_ras_tos_i_2(a_ras[2]),
    .alloc_ready_o(ready), .alloc_tag_o_0(tag0), .alloc_tag_o_1(tag1), .alloc_tag_o_2(tag2),
    .resolve_valid_i(rv),
    .resolve_tag_i_0(rs_tag[0]), .resolve_tag_i_1(rs_tag[1]), .resolve_tag_i_2(rs_tag[2]),
    .resolve_mispredict_i(rm),
    .resolve_correct_pc_i_0(rs_cpc[0]), .resolve_correct_pc_i_1(rs_cpc[1]),
    .resolve_correct_pc_i_2(rs_cpc[2]),
    .misprediction_o_0(d_mp[0]), .misprediction_o_1(d_mp[1]), .misprediction_o_2(d_mp[2]),
    .update_valid_o_0(d_uv[0]), .update_valid_o_1(d_uv[1]), .update_valid_o_2(d_uv[2]),
    .is_jalr_o_0(d_jalr[0]), .is_jalr_o_1(d_jalr[1]), .is_jalr_o_2(d_jalr[2]),
    .pc_at_prediction_o_0(d_pc[0]), .pc_at_prediction_o_1(d_pc[1]),
    .pc_at_prediction_o_2(d_pc[2]),
    .correct_pc_o_0(d_cpc[0]), .correct_pc_o_1(d_cpc[1]), .correct_pc_o_2(d_cpc[2]),
    .update_global_history_o_0(d_hist[0]), .update_global_history_o_1(d_hist[1]),
    .update_global_history_o_2(d_hist[2]),
    .ras_restore_en_o(ras_en), .ras_restore_tos_o(ras_tos),
    .empty_o(empty), .full_o(full), .count_o(count),
    .mispredict_count_o(misp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] pc;
    logic [31:0] cpc;
    logic [7:0]  hist;
    logic        jalr;
    logic [2:0]  ras;
    logic        res;
    logic        misp;
  } ent_t;

  ent_t        q[$];
  logic [3:0]  m_tail;
  logic [31:0] m_cnt;
  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef BRQ_PERF_COUNTERS_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  task automatic idle();
    av = '0; aj = '0; rv = '0; rm = '0;
    for (int k = 0; k < 3; k++) begin
      a_pc[k] = '0; a_hist[k] = '0; a_ras[k] = '0; rs_tag[k] = '0; rs_cpc[k] = '0;
    end
  endtask

  task automatic alloc(int n, logic [31:0] base);
    av = 3'((1 << n) - 1);
    for (int k = 0; k < 3; k++) begin
      a_pc[k]   = base + 32'(4 * k);
      a_hist[k] = 8'($urandom);
      a_ras[k]  = 3'($urandom);
      aj[k]     = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic res(int p, logic [3:0] t, logic mp, logic [31:0] cpc);
    rv[p] = 1'b1; rs_tag[p] = t; rm[p] = mp; rs_cpc[p] = cpc;
  endtask

  // Resolve up to three distinct unresolved entries picked from the model
  task automatic rand_res(int pct);
    int cand[$];
    int j;
    foreach (q[i]) if (!q[i].res) cand.push_back(i);
    for (int p = 0; p < 3; p++) begin
      if (cand.size() > 0) begin
        j = int'($urandom_range(0, cand.size() - 1));
        res(p, q[cand[j]].tag, int'($urandom_range(0, 99)) < pct, $urandom);
        cand.delete(j);
      end
    end
  endtask

  // Check this cycle's outputs against the model, then advance the model across the edge
  task automatic step();
    int n;
    bit m, rdy;
    ent_t e;
    @(negedge clk);
    n = 0; m = 0;
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      if (!q[i].res) break;
      n++;
      if (q[i].misp) begin m = 1; break; end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("update_valid_%0d", k), d_uv[k], k < n);
      chk($sformatf("misprediction_%0d", k), d_mp[k], (k < n) ? q[k].misp : 1'b0);
      if (k < n) begin
        chk($sformatf("pc_%0d", k), d_pc[k], q[k].pc);
        chk($sformatf("correct_pc_%0d", k), d_cpc[k], q[k].cpc);
        chk($sformatf("history_%0d", k), d_hist[k], q[k].hist);
        chk($sformatf("is_jalr_%0d", k), d_jalr[k], q[k].jalr);
      end else begin
        chk($sformatf("idle_pc_%0d", k), d_pc[k], 0);
        chk($sformatf("idle_cpc_%0d", k), d_cpc[k], 0);
      end
    end
    chk("ras_restore_en", ras_en, m);
    chk("ras_restore_tos", ras_tos, m ? q[n-1].ras : 3'd0);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == 16);
    rdy = (16 - q.size()) >= 3;
    chk("alloc_ready", ready, rdy);
    chk("alloc_tag_0", tag0, m_tail);
    chk("alloc_tag_2", tag2, 4'(m_tail + 4'd2));
    chk("mispredict_count", misp_cnt, exp_cnt());

    if (reset) begin
      q.delete(); m_tail = '0; m_cnt = '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (rv[p]) begin
          for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == rs_tag[p] && !q[i].res) begin
              e = q[i]; e.res = 1'b1; e.misp = rm[p]; e.cpc = rs_cpc[p]; q[i] = e;
              break;
            end
          end
        end
      end
      if (m) begin
        m_tail = q[n-1].tag + 4'd1;
        q.delete();
        m_cnt = m_cnt + 32'd1;
      end else begin
        repeat (n) void'(q.pop_front());
        if (rdy) begin
          for (int k = 0; k < 3; k++) begin
            if (av[k]) begin
              e.tag = m_tail; e.pc = a_pc[k]; e.cpc = '0; e.hist = a_hist[k];
              e.jalr = aj[k]; e.ras = a_ras[k]; e.res = 1'b0; e.misp = 1'b0;
              q.push_back(e);
              m_tail = m_tail + 4'd1;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    m_tail = '0; m_cnt = '0;
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Reset state
    step();
    chk("reset_empty", empty, 1'b1);
    chk("reset_ready", ready, 1'b1);
    reset = 1'b0;

    // In-order emission after out-of-order resolves
    alloc(3, 32'h100); step();
    res(0, 4'd2, 1'b0, 32'h1002); step();
    res(0, 4'd1, 1'b0, 32'h1001); step();
    chk("ooo_no_early_emit", d_uv, 3'b000);
    res(0, 4'd0, 1'b0, 32'h1000); step();
    chk("ooo_all_emit", d_uv, 3'b111);
    chk("ooo_pc0", d_pc[0], 32'h100);
    chk("ooo_pc2", d_pc[2], 32'h108);
    step();
    chk("ooo_count_zero", count, 5'd0);

    // Mispredict on second emitted slot flushes the rest
    alloc(3, 32'h200); step();
    alloc(1, 32'h300); step();
    res(0, 4'd6, 1'b0, 32'h60); res(1, 4'd5, 1'b0, 32'h50); res(2, 4'd4, 1'b1, 32'h200);
    step();
    res(0, 4'd3, 1'b0, 32'h204); step();
    chk("flush_uv", d_uv, 3'b011);
    chk("flush_mp", d_mp, 3'b010);
    chk("flush_cpc1", d_cpc[1], 32'h200);
    chk("flush_ras_en", ras_en, 1'b1);
    alloc(2, 32'h400); step();
    chk("flush_count", count, 5'd0);
    chk("flush_empty", empty, 1'b1);

    // Stray and duplicate resolves are ignored; first target is kept
    res(0, 4'd9, 1'b1, 32'hdead); step();
    alloc(2, 32'h500); step();
    res(0, 4'd6, 1'b0, 32'h300); step();
    res(1, 4'd6, 1'b1, 32'h999); step();
    res(0, 4'd5, 1'b0, 32'h504); step();
    chk("dup_uv", d_uv, 3'b011);
    chk("dup_mp1", d_mp[1], 1'b0);
    chk("dup_cpc1", d_cpc[1], 32'h300);
    step();

    // Back-pressure at 14 entries
    for (int i = 0; i < 4; i++) begin alloc(3, 32'h1000 + 32'(i * 16)); step(); end
    alloc(2, 32'h2000); step();
    chk("bp_count14", count, 5'd14);
    chk("bp_not_ready", ready, 1'b0);
    alloc(3, 32'h3000); step();
    res(0, q[0].tag, 1'b0, 32'h44); step();
    step();
    chk("bp_ready_again", ready, 1'b1);
    for (int g = 0; g < 40 && q.size() > 0; g++) begin rand_res(0); step(); end
    chk("bp_drained", empty, 1'b1);

    // Mixed random traffic, tags wrap many times
    for (int i = 0; i < 80; i++) begin
      alloc(int'($urandom_range(0, 3)), 32'h8000 + 32'(i * 16));
      rand_res(12);
      step();
    end
    for (int g = 0; g < 40 && q.size() > 0; g++) begin rand_res(0); step(); end
    chk("wrap_drained", empty, 1'b1);

    // Reset mid-stream with a pending mispredict
    alloc(3, 32'hA00); step();
    alloc(2, 32'hB00); step();
    res(0, q[2].tag, 1'b1, 32'hC00); step();
    reset = 1'b1;
    alloc(3, 32'hD00); res(0, q[0].tag, 1'b0, 32'hE00);
    step();
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 5'd0);
    chk("rst_uv", d_uv, 3'b000);
    chk("rst_misp_cnt", misp_cnt, 32'd0);
    reset = 1'b0;
    alloc(2, 32'hF00); step();
    res(0, 4'd1, 1'b0, 32'h11); res(1, 4'd0, 1'b0, 32'h10); step();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
